// File: rtl/fp_result_packer.sv
// Packs adder results into a FIFO, with sticky exception flags and a counter of results dropped because the FIFO was full.
// Build option: define FP_PACK_CANON_NAN_EN to store every NaN as the canonical 32'h7FC00000.
module fp_result_packer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     Sz,
   input  logic [7:0]               Ez,
   input  logic [22:0]              Mz,
   input  logic [4:0]               in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [4:0]               out_flags,
   output logic [4:0]               sticky_flags,
   input  logic                     flag_clr,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [31:0]      data_mem_q [DEPTH];
   logic [4:0]       flag_mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [4:0]       sticky_q, sticky_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [31:0]      push_data;
   logic             pop, push, drop, full;

   always_comb begin
      push_data = {Sz, Ez, Mz};
`ifdef FP_PACK_CANON_NAN_EN
      if (Ez == 8'hFF && Mz != 23'd0) push_data = 32'h7FC0_0000;
`endif
   end

   always_comb begin
      full = (level_q == DEPTH_L);
      pop  = out_valid & out_ready;
      push = in_valid & (~full | pop);
      drop = in_valid & full & ~pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;

      drop_d = (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;

      // New flags arriving with a clear take precedence over the clear
      sticky_d = sticky_q;
      if (flag_clr) sticky_d = in_valid ? in_flags : 5'd0;
      else if (in_valid) sticky_d = sticky_q | in_flags;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sticky_q <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sticky_q <= sticky_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= push_data;
         flag_mem_q[wr_ptr_q] <= in_flags;
      end
   end

   // Storage is not reset; the head is masked to zero whenever the FIFO is empty
   assign out_valid    = (level_q != '0);
   assign out_data     = out_valid ? data_mem_q[rd_ptr_q] : 32'd0;
   assign out_flags    = out_valid ? flag_mem_q[rd_ptr_q] : 5'd0;
   assign sticky_flags = sticky_q;
   assign level        = level_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed bench for fp_result_packer: queue-based reference model compared every cycle, plus literal checks.
module tb_fp_result_packer;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, Sz = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
   logic [7:0]  Ez = 8'd0;
   logic [22:0] Mz = 23'd0;
   logic [4:0]  in_flags = 5'd0;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_flags, sticky_flags;
   logic [2:0]  level;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   fp_result_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .Sz(Sz), .Ez(Ez), .Mz(Mz),
      .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_flags(out_flags), .sticky_flags(sticky_flags),
      .flag_clr(flag_clr), .level(level), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] m);
      logic [31:0] w;
      w = {s, e, m};
`ifdef FP_PACK_CANON_NAN_EN
      if (e == 8'hFF && m != 23'd0) w = 32'h7FC0_0000;
`endif
      return w;
   endfunction

   // Reference model: a queue of {flags, word}, a saturating drop count and a flag accumulator
   logic [36:0] mq[$];
   int          m_drop = 0;
   logic [4:0]  m_sticky = 5'd0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_drop   = 0;
         m_sticky = 5'd0;
      end else begin
         bit was_full, do_pop;
         was_full = (mq.size() == DEPTH);
         do_pop   = (mq.size() > 0) && out_ready;
         if (flag_clr) m_sticky = in_valid ? in_flags : 5'd0;
         else if (in_valid) m_sticky = m_sticky | in_flags;
         if (do_pop) void'(mq.pop_front());
         if (in_valid) begin
            if (!was_full || do_pop) mq.push_back({in_flags, pack(Sz, Ez, Mz)});
            else if (m_drop < (1 << CNT_W) - 1) m_drop++;
         end
      end
   end

   always @(negedge clk) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("out_data", 64'(out_data), (mq.size() > 0) ? 64'(mq[0][31:0]) : 64'd0);
      check("out_flags", 64'(out_flags), (mq.size() > 0) ? 64'(mq[0][36:32]) : 64'd0);
      check("level", 64'(level), 64'(mq.size()));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("sticky", 64'(sticky_flags), 64'(m_sticky));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m, input logic [4:0] f);
      in_valid = v; Sz = s; Ez = e; Mz = m; in_flags = f;
   endtask

   initial begin
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_sticky", 64'(sticky_flags), 64'd0);
      step(); step();
      rst = 1'b1;
      step();

      // Basic one-cycle latency
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 8'hF0, 23'h700000, 5'b00010);
      step();
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("lat_valid", 64'(out_valid), 64'd1);
      check("lat_data", 64'(out_data), 64'h78700000);
      check("lat_flags", 64'(out_flags), 64'h02);
      check("lat_sticky", 64'(sticky_flags), 64'h02);
      step();
      check("lat_drain_level", 64'(level), 64'd0);

      // Overfill with no consumer: 6 pushes into 4 entries
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 8'h10 + 8'(i), 23'(i + 1), 5'(i));
         step();
      end
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("over_level", 64'(level), 64'd4);
      check("over_drop", 64'(drop_cnt), 64'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("over_order", 64'(out_data), 64'({1'b0, 8'h10 + 8'(i), 23'(i + 1)}));
         step();
      end
      check("over_empty", 64'(out_valid), 64'd0);

      // Full FIFO with simultaneous push and pop
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'h7F, 23'(i), 5'b00000);
         step();
      end
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 8'h80, 23'h12345, 5'b00001);
      step();
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("full_pp_level", 64'(level), 64'd4);
      check("full_pp_drop", 64'(drop_cnt), 64'd2);
      for (int i = 1; i < 4; i++) begin
         check("full_pp_order", 64'(out_data), 64'({1'b0, 8'h7F, 23'(i)}));
         step();
      end
      check("full_pp_last", 64'(out_data), 64'hC0012345);
      check("full_pp_last_flags", 64'(out_flags), 64'h01);
      step();

      // Drop counter saturation
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 8'h01, 23'h1, 5'b00000);
      for (int i = 0; i < 4 + 260; i++) step();
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("drop_sat", 64'(drop_cnt), 64'hFF);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Sticky flag clear versus new flags
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      check("clr_alone0", 64'(sticky_flags), 64'h00);
      drive(1'b1, 1'b0, 8'h3F, 23'h0, 5'b01000);
      step();
      check("sticky_set", 64'(sticky_flags), 64'h08);
      flag_clr = 1'b1;
      drive(1'b1, 1'b0, 8'h3F, 23'h0, 5'b10000);
      step();
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("clr_vs_new", 64'(sticky_flags), 64'h10);
      step();
      flag_clr = 1'b0;
      check("clr_alone", 64'(sticky_flags), 64'h00);
      step();

      // NaN payload handling
      drive(1'b1, 1'b1, 8'hFF, 23'h000001, 5'b10000);
      step();
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
`ifdef FP_PACK_CANON_NAN_EN
      check("nan_data", 64'(out_data), 64'h7FC00000);
`else
      check("nan_data", 64'(out_data), 64'hFF800001);
`endif
      check("nan_flags", 64'(out_flags), 64'h10);
      step();

      // Asynchronous reset with entries held
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'h55, 23'(i), 5'b00100);
         step();
      end
      drive(1'b0, 1'b0, 8'h00, 23'h0, 5'b00000);
      check("pre_rst_level", 64'(level), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_level", 64'(level), 64'd0);
      check("arst_drop", 64'(drop_cnt), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      step(); step();
      check("post_rst_level", 64'(level), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
